// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ID/EX register, ALU, data-SRAM request, iterative HI/LO divider
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [5:0]   stall,
    input  logic [151:0] id_to_ex_bus,
    output logic [81:0]  ex_to_mem_bus,
    output logic [37:0]  ex_to_rf_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_wen,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata,
    output logic         stallreq_for_ex,
    output logic         hilo_we,
    output logic [31:0]  hi_wdata,
    output logic [31:0]  lo_wdata
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV_ON,
        S_DIV_END
    } div_state_e;

    logic [151:0] id_ex_q, id_ex_d;

    always_comb begin
        id_ex_d = id_ex_q;
        if (rst) begin
            id_ex_d = '0;
        end else if (stall[2] && !stall[3]) begin
            id_ex_d = '0;
        end else if (!stall[2]) begin
            id_ex_d = id_to_ex_bus;
        end
    end

    always_ff @(posedge clk) begin
        id_ex_q <= id_ex_d;
    end

    logic [1:0]  div_op;
    logic [31:0] rt_data;
    logic [3:0]  alu_op;
    logic [5:0]  ld_st_op;
    logic [31:0] pc;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;

    assign div_op       = id_ex_q[151:150];
    assign rt_data      = id_ex_q[149:118];
    assign alu_op       = id_ex_q[117:114];
    assign ld_st_op     = id_ex_q[113:108];
    assign pc           = id_ex_q[107:76];
    assign src_a        = id_ex_q[75:44];
    assign src_b        = id_ex_q[43:12];
    assign data_ram_en  = id_ex_q[11];
    assign data_ram_wen = id_ex_q[10:7];
    assign sel_rf_res   = id_ex_q[6];
    assign rf_we        = id_ex_q[5];
    assign rf_waddr     = id_ex_q[4:0];

    logic [31:0] ex_result;

    always_comb begin
        ex_result = '0;
        case (alu_op)
            4'd0:    ex_result = src_a + src_b;
            4'd1:    ex_result = src_a - src_b;
            4'd2:    ex_result = src_a & src_b;
            4'd3:    ex_result = src_a | src_b;
            4'd4:    ex_result = src_a ^ src_b;
            4'd5:    ex_result = ~(src_a | src_b);
            4'd6:    ex_result = {31'b0, $signed(src_a) < $signed(src_b)};
            4'd7:    ex_result = {31'b0, src_a < src_b};
            4'd8:    ex_result = src_b << src_a[4:0];
            4'd9:    ex_result = src_b >> src_a[4:0];
            4'd10:   ex_result = $signed(src_b) >>> src_a[4:0];
            4'd11:   ex_result = {src_b[15:0], 16'b0};
            default: ex_result = '0;
        endcase
    end

    assign ex_to_mem_bus = {ld_st_op, pc, data_ram_en, data_ram_wen, sel_rf_res,
                            rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

    assign data_sram_en    = data_ram_en;
    assign data_sram_wen   = data_ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = rt_data;

    // Divider: magnitudes are divided unsigned, signs are restored on entry to DIV_END.
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic [31:0]      dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic        div_valid;
    logic        div_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] trial;
    logic [32:0] trial_sub;
    logic        trial_ge;
    logic [31:0] rem_step;
    logic [31:0] quo_step;

    assign div_valid  = (div_op == 2'b01) || (div_op == 2'b10);
    assign div_signed = (div_op == 2'b01);
    assign abs_a      = (div_signed && src_a[31]) ? -src_a : src_a;
    assign abs_b      = (div_signed && src_b[31]) ? -src_b : src_b;

    // Restoring step: bring down the next dividend bit, subtract when it fits.
    assign trial     = {rem_q, quo_q[31]};
    assign trial_sub = trial - {1'b0, dvs_q};
    assign trial_ge  = (trial >= {1'b0, dvs_q});
    assign rem_step  = trial_ge ? trial_sub[31:0] : trial[31:0];
    assign quo_step  = {quo_q[30:0], trial_ge};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (rst) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = '0;
            dvs_d   = '0;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            hi_d    = '0;
            lo_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_valid) begin
                        if (src_b == 32'd0) begin
                            state_d = S_DIV_END;
                            hi_d    = '0;
                            lo_d    = '0;
                        end else begin
                            state_d = S_DIV_ON;
                            cnt_d   = '0;
                            rem_d   = '0;
                            quo_d   = abs_a;
                            dvs_d   = abs_b;
                            q_neg_d = div_signed && (src_a[31] ^ src_b[31]);
                            r_neg_d = div_signed && src_a[31];
                        end
                    end
                end
                S_DIV_ON: begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
                        state_d = S_DIV_END;
                        cnt_d   = '0;
                        hi_d    = r_neg_q ? -rem_step : rem_step;
                        lo_d    = q_neg_q ? -quo_step : quo_step;
                    end
                end
                S_DIV_END: begin
                    if (!stall[2]) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        rem_q   <= rem_d;
        quo_q   <= quo_d;
        dvs_q   <= dvs_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
        hi_q    <= hi_d;
        lo_q    <= lo_d;
    end

    assign stallreq_for_ex = ((state_q == S_IDLE) && div_valid) || (state_q == S_DIV_ON);
    assign hilo_we         = (state_q == S_DIV_END) && !stall[2];
    assign hi_wdata        = hi_q;
    assign lo_wdata        = lo_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized and directed checks of ex_stage against an in-bench reference model
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [151:0] id_to_ex_bus;
    logic [81:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_rf_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         stallreq_for_ex;
    logic         hilo_we;
    logic [31:0]  hi_wdata;
    logic [31:0]  lo_wdata;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_rf_bus    (ex_to_rf_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex),
        .hilo_we         (hilo_we),
        .hi_wdata        (hi_wdata),
        .lo_wdata        (lo_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: the instruction sitting in EX, plus divide progress as a countdown.
    logic [151:0] m_reg   = '0;
    bit           m_valid = 1'b0;
    int           m_phase = 0;
    int           m_left  = 0;
    logic [31:0]  m_q     = '0;
    logic [31:0]  m_r     = '0;

    task automatic chk(input string name, input logic [151:0] act, input logic [151:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << a[4:0];
            4'd9:  return b >> a[4:0];
            4'd10: return 32'((sb >>> a[4:0]));
            4'd11: return b * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_div_valid();
        return (m_reg[151:150] == 2'b01) || (m_reg[151:150] == 2'b10);
    endfunction

    function automatic bit m_stallreq();
        return (m_phase == 0 && m_div_valid()) || (m_phase == 1);
    endfunction

    task automatic compare();
        logic [31:0] res;
        bit          exp_we;
        if (!m_valid) return;
        res = ref_alu(m_reg[117:114], m_reg[75:44], m_reg[43:12]);
        chk("mem_bus", ex_to_mem_bus, {m_reg[113:108], m_reg[107:76], m_reg[11], m_reg[10:7],
                                       m_reg[6], m_reg[5], m_reg[4:0], res});
        chk("rf_bus", ex_to_rf_bus, {m_reg[5], m_reg[4:0], res});
        chk("sram_en", data_sram_en, m_reg[11]);
        chk("sram_wen", data_sram_wen, m_reg[10:7]);
        chk("sram_addr", data_sram_addr, res);
        chk("sram_wdata", data_sram_wdata, m_reg[149:118]);
        chk("stallreq", stallreq_for_ex, m_stallreq());
        exp_we = (m_phase == 2) && !stall[2];
        chk("hilo_we", hilo_we, exp_we);
        if (exp_we) begin
            chk("hi_wdata", hi_wdata, m_r);
            chk("lo_wdata", lo_wdata, m_q);
        end
    endtask

    task automatic model_step();
        logic [31:0] a, b;
        longint x, y, q, r;
        if (rst) begin
            m_reg   = '0;
            m_phase = 0;
            m_valid = 1'b1;
            return;
        end
        if (!m_valid) return;
        a = m_reg[75:44];
        b = m_reg[43:12];
        case (m_phase)
            0: if (m_div_valid()) begin
                if (b == 32'd0) begin
                    m_q     = '0;
                    m_r     = '0;
                    m_phase = 2;
                end else begin
                    if (m_reg[151:150] == 2'b01) begin
                        x = $signed(a);
                        y = $signed(b);
                    end else begin
                        x = longint'({32'b0, a});
                        y = longint'({32'b0, b});
                    end
                    q       = x / y;
                    r       = x % y;
                    m_q     = q[31:0];
                    m_r     = r[31:0];
                    m_phase = 1;
                    m_left  = 32;
                end
            end
            1: begin
                m_left--;
                if (m_left == 0) m_phase = 2;
            end
            default: if (!stall[2]) m_phase = 0;
        endcase
        if (stall[2] && !stall[3]) m_reg = '0;
        else if (!stall[2]) m_reg = id_to_ex_bus;
    endtask

    task automatic cyc(input logic [151:0] bus, input logic [5:0] st, input logic r);
        id_to_ex_bus = bus;
        stall        = st;
        rst          = r;
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [151:0] mk(input logic [1:0] dop, input logic [31:0] rt,
                                        input logic [3:0] op, input logic [5:0] ldst,
                                        input logic [31:0] pc, input logic [31:0] a,
                                        input logic [31:0] b, input logic en,
                                        input logic [3:0] wen, input logic sel,
                                        input logic we, input logic [4:0] wa);
        return {dop, rt, op, ldst, pc, a, b, en, wen, sel, we, wa};
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom % 8)
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom % 64);
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [151:0] rand_ins();
        logic [1:0] dop;
        case ($urandom % 12)
            0: dop = 2'b01;
            1: dop = 2'b10;
            2: dop = 2'b11;
            default: dop = 2'b00;
        endcase
        return mk(dop, $urandom, 4'($urandom), 6'($urandom), $urandom, rand_val(), rand_val(),
                  1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
    endfunction

    task automatic run_div(input string name, input logic [151:0] ins, input int exp_n,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi, input int hold);
        int n;
        n = 0;
        cyc(ins, 6'b000000, 1'b0);
        for (int i = 0; i < 60; i++) begin
            if (!stallreq_for_ex) break;
            n++;
            cyc('0, 6'b001111, 1'b0);
        end
        chk({name, "_stall_cycles"}, 152'(n), 152'(exp_n));
        for (int h = 0; h < hold; h++) begin
            stall = 6'b001100;
            #1;
            chk({name, "_held_we"}, hilo_we, 1'b0);
            cyc('0, 6'b001100, 1'b0);
        end
        stall = 6'b000000;
        #1;
        chk({name, "_we"}, hilo_we, 1'b1);
        chk({name, "_lo"}, lo_wdata, exp_lo);
        chk({name, "_hi"}, hi_wdata, exp_hi);
        cyc('0, 6'b000000, 1'b0);
        chk({name, "_we_after"}, hilo_we, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] st;
        logic       r;
        id_to_ex_bus = '0;
        stall        = '0;
        rst          = 1'b1;

        cyc('0, 6'b000000, 1'b1);
        cyc('0, 6'b000000, 1'b1);
        chk("rst_mem_bus", ex_to_mem_bus, '0);
        chk("rst_stallreq", stallreq_for_ex, 1'b0);
        chk("rst_hilo_we", hilo_we, 1'b0);
        chk("rst_hilo", {hi_wdata, lo_wdata}, '0);

        cyc(mk(2'b00, 0, 4'd0, 0, 32'h40, 32'd5, 32'd7, 0, 0, 0, 1, 5'd3), 6'b000000, 1'b0);
        chk("add_rf_bus", ex_to_rf_bus, {1'b1, 5'd3, 32'd12});
        cyc(mk(2'b00, 0, 4'd10, 0, 0, 32'd4, 32'h8000_0000, 0, 0, 0, 1, 5'd4), 6'b000000, 1'b0);
        chk("sra", ex_to_mem_bus[31:0], 32'hF800_0000);

        cyc(mk(2'b00, 32'hDEAD_BEEF, 4'd0, 6'b101011, 0, 32'h100, 32'd4, 1, 4'hF, 0, 0, 0),
            6'b000000, 1'b0);
        chk("sw_addr", data_sram_addr, 32'h104);
        chk("sw_wdata", data_sram_wdata, 32'hDEAD_BEEF);
        chk("sw_en_wen", {data_sram_en, data_sram_wen}, 5'b1_1111);
        cyc(mk(2'b00, 0, 4'd0, 6'b100011, 0, 32'h200, 32'd8, 1, 4'h0, 1, 1, 5'd9),
            6'b000000, 1'b0);
        chk("lw_en_wen", {data_sram_en, data_sram_wen}, 5'b1_0000);
        chk("lw_ldst", ex_to_mem_bus[81:76], 6'b100011);

        cyc(mk(2'b00, 0, 4'd0, 0, 0, 32'd1, 32'd2, 0, 0, 0, 1, 5'd5), 6'b000000, 1'b0);
        cyc(mk(2'b00, 0, 4'd3, 0, 0, 32'd9, 32'd9, 0, 0, 0, 1, 5'd6), 6'b000100, 1'b0);
        chk("bubble", ex_to_mem_bus, '0);
        cyc(mk(2'b00, 0, 4'd0, 0, 0, 32'd10, 32'd20, 0, 0, 0, 1, 5'd7), 6'b000000, 1'b0);
        cyc(mk(2'b00, 0, 4'd0, 0, 0, 32'd1, 32'd1, 0, 0, 0, 1, 5'd8), 6'b001100, 1'b0);
        chk("hold_rf_bus", ex_to_rf_bus, {1'b1, 5'd7, 32'd30});

        run_div("sdiv", mk(2'b01, 0, 0, 0, 0, -32'sd7, 32'd2, 0, 0, 0, 0, 0), 33,
                32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run_div("divu", mk(2'b10, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'd16, 0, 0, 0, 0, 0), 33,
                32'h0FFF_FFFF, 32'h0000_000F, 0);
        run_div("div0", mk(2'b01, 0, 0, 0, 0, 32'd123, 32'd0, 0, 0, 0, 0, 0), 1,
                32'd0, 32'd0, 0);
        run_div("minneg", mk(2'b01, 0, 0, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0), 33,
                32'h8000_0000, 32'd0, 0);
        run_div("hold", mk(2'b10, 0, 0, 0, 0, 32'd100, 32'd7, 0, 0, 0, 0, 0), 33,
                32'd14, 32'd2, 3);

        cyc(mk(2'b01, 0, 0, 0, 0, 32'd1000, 32'd3, 0, 0, 0, 0, 0), 6'b000000, 1'b0);
        for (int i = 0; i < 10; i++) cyc('0, 6'b001111, 1'b0);
        cyc('0, 6'b000000, 1'b1);
        chk("rstmid_stallreq", stallreq_for_ex, 1'b0);
        chk("rstmid_hilo_we", hilo_we, 1'b0);
        chk("rstmid_mem_bus", ex_to_mem_bus, '0);

        for (int i = 0; i < 4000; i++) begin
            if (m_stallreq()) begin
                st = 6'b001111;
            end else begin
                case ($urandom % 8)
                    5: st = 6'b000100;
                    6: st = 6'b001100;
                    7: st = 6'b001111;
                    default: st = 6'b000000;
                endcase
            end
            r = ($urandom_range(0, 299) == 0);
            cyc(rand_ins(), st, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline, between the ID stage and the MEM stage.
- Latches the ID→EX bus and computes the ALU result.
- Issues the data-SRAM request for loads and stores, and packs the 82-bit EX→MEM bus that MEM consumes.
- Contains an iterative 32-cycle signed/unsigned divider that writes HI/LO and stalls the pipeline through `stallreq_for_ex`.

Parameters:
- DIV_CYCLES, 32, number of iteration cycles in DIV_ON; one quotient bit per cycle.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- stall  input  6  pipeline stall vector; bit 2 = EX, bit 3 = MEM; 1 = Stop
- id_to_ex_bus  input  152  see layout below
- ex_to_mem_bus  output  82  {ld_st_op[81:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
- ex_to_rf_bus  output  38  forwarding path {rf_we, rf_waddr[4:0], ex_result[31:0]}
- data_sram_en  output  1  SRAM enable
- data_sram_wen  output  4  byte write enables
- data_sram_addr  output  32  SRAM address
- data_sram_wdata  output  32  store data
- stallreq_for_ex  output  1  divider busy; asks the controller to stall
- hilo_we  output  1  HI/LO write strobe
- hi_wdata  output  32  remainder
- lo_wdata  output  32  quotient

Behaviour:
- id_to_ex_bus layout, MSB→LSB:
  - div_op[151:150]: 00 none, 01 signed div, 10 divu, 11 treated as none
  - rt_data[149:118]
  - alu_op[117:114]
  - ld_st_op[113:108]
  - pc[107:76]
  - src_a[75:44]
  - src_b[43:12]
  - data_ram_en[11], data_ram_wen[10:7], sel_rf_res[6], rf_we[5], rf_waddr[4:0]
- Input register, priority order:
  - rst → 0.
  - stall[2]=1 and stall[3]=0 → 0 (bubble).
  - stall[2]=0 → load id_to_ex_bus.
  - Otherwise hold.
- ALU (combinational from the register), alu_op:
  - 0 add, 1 sub (both wrap mod 2^32, no overflow trap), 2 and, 3 or, 4 xor, 5 nor
  - 6 slt (signed), 7 sltu (result 0/1, zero-extended)
  - 8 sll, 9 srl, 10 sra: value src_b, shift amount src_a[4:0]
  - 11 lui: src_b<<16
  - 12–15: result 0
- Memory request:
  - data_sram_en = data_ram_en; data_sram_wen = data_ram_wen; data_sram_addr = ex_result; data_sram_wdata = rt_data.
  - A bubble (all-zero register) issues no access.
- ex_to_mem_bus: fields copied from the register; ex_result is the ALU result.
- Divider FSM states: IDLE, DIV_ON, DIV_END. Reset → IDLE, counter 0, all outputs 0.
  - IDLE, div_op∈{01,10}, divisor src_b≠0:
    - Capture |src_a|, |src_b| (divu: raw values) and sign flags.
    - → DIV_ON, counter 0.
  - IDLE, div_op valid, src_b=0: → DIV_END with q=0, r=0.
  - DIV_ON: one restoring shift-subtract step per cycle; counter +1. When counter = DIV_CYCLES-1, → DIV_END.
  - DIV_END:
    - Sign fix-up: signed div negates q if the operand signs differ; r takes the dividend's sign.
    - hi_wdata = r, lo_wdata = q (held stable while in DIV_END).
    - Stay in DIV_END while stall[2]=1. When stall[2]=0, → IDLE on the same edge the instruction advances to MEM.
- stallreq_for_ex:
  - 1 when state=IDLE and div_op is valid, or state=DIV_ON.
  - 0 in DIV_END and for non-divide instructions.
- hilo_we = 1 only in DIV_END with stall[2]=0 (exactly one cycle per divide).
- Divide latency: instruction in the EX register at cycle T → stallreq high T..T+32 → DIV_END at T+33.
- Divide by zero: DIV_END at T+1.
- Reset mid-division: FSM → IDLE, counter 0, partial result discarded, stallreq 0 the next cycle.
- Edge cases:
  - Signed 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0 (wraps).
  - Divide instructions carry rf_we=0 from ID; this block does not check it.

Test Plan:
- add 5+7, rf_waddr=3 → ex_result=12, ex_to_rf_bus={1,3,12} the same cycle; sra 0x80000000 by 4 → 0xF8000000.
- sw src_a=0x100, src_b=4, rt_data=0xDEADBEEF, wen=1111 → sram addr 0x104, wdata 0xDEADBEEF, en=1, wen=1111; lw ld_st_op=6'b100011 → en=1, wen=0000, ex_to_mem_bus[81:76]=100011.
- Signed div −7/2 → stallreq high 33 cycles; at T+33 hilo_we=1 for one cycle, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 0xFFFFFFFF/16 → lo=0x0FFFFFFF, hi=0xF.
- Divide by zero → stallreq for 1 cycle; then hilo_we=1, hi=lo=0.
- stall=6'b000100 for one cycle → ex_to_mem_bus=0 next cycle; stall=6'b001100 → register holds. A divide in DIV_END held by stall[2] for 3 cycles → hilo_we stays 0 until release, then pulses once.
- Assert rst at iteration 10 of a divide → next cycle state IDLE, stallreq=0, hilo_we=0, ex_to_mem_bus=0.
